// File: rtl/cdr_lf_if.sv
// Bundle between the bang-bang phase detector and the CDR loop filter.
// pd_valid has no ready: the filter consumes a sample in every cycle where pd_valid is high and freeze is low.
interface cdr_lf_if;
  logic               pd_valid;
  logic               pd_up;
  logic               pd_dn;
  logic               freeze;
  logic signed [31:0] v_ctrl;
  logic               win_done;
  logic               locked;
  logic               sat;
  logic               lock_state;  // debug view of the ACQ(0)/LOCKED(1) state register

  modport master (
    output pd_valid, pd_up, pd_dn, freeze,
    input  v_ctrl, win_done, locked, sat, lock_state
  );

  modport slave (
    input  pd_valid, pd_up, pd_dn, freeze,
    output v_ctrl, win_done, locked, sat, lock_state
  );
endinterface

// File: rtl/cdr_loop_filter.sv
// Decimating PI loop filter for the CDR with a saturating integrator and lock detection.
// Optional macro CDR_LF_GEAR_SHIFT_EN raises both gains by GEAR while acquiring.
module cdr_loop_filter #(
  parameter int DECIM      = 16,
  parameter int KP_SHIFT   = 16,
  parameter int KI_SHIFT   = 8,
  parameter int V_MAX      = 2**30-1,
  parameter int LOCK_THR   = 2,
  parameter int UNLOCK_THR = 8,
  parameter int LOCK_CNT   = 4,
  parameter int GEAR       = 4
) (
  input logic     clk,
  input logic     rst,
  cdr_lf_if.slave lf
);
  localparam int CW = $clog2(DECIM);
  localparam int SW = CW + 2;
  localparam int AW = 40;
  localparam int QW = $clog2(LOCK_CNT + 1);
  localparam logic signed [AW-1:0] VMAX = AW'(V_MAX);
`ifdef CDR_LF_GEAR_SHIFT_EN
  localparam int GEAR_EFF = GEAR;
`else
  localparam int GEAR_EFF = 0 * GEAR;
`endif

  typedef enum logic {ACQ = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state_q, state_n;
  logic [QW-1:0]          quiet_q, quiet_n;
  logic [CW-1:0]          cnt_q;
  logic signed [SW-1:0]   sum_q, vote, sum_fin;
  logic [SW-1:0]          s_abs;
  int                     s_mag;
  logic signed [31:0]     integ_q, v_ctrl_q;
  logic                   win_done_q, sat_q;
  logic                   accept, close;
  int                     ki, kp;
  logic signed [AW-1:0]   s_ext, integ_ext, integ_n, v_n;

  function automatic logic signed [AW-1:0] clamp(input logic signed [AW-1:0] x);
    if (x > VMAX)       return VMAX;
    else if (x < -VMAX) return -VMAX;
    else                return x;
  endfunction

  always_comb begin
    vote = '0;
    if (lf.pd_up && !lf.pd_dn)      vote = SW'(1);
    else if (lf.pd_dn && !lf.pd_up) vote = {SW{1'b1}};
  end

  assign accept  = lf.pd_valid && !lf.freeze;
  assign close   = accept && (cnt_q == CW'(DECIM - 1));
  assign sum_fin = sum_q + vote;
  assign s_abs   = sum_fin[SW-1] ? SW'(-sum_fin) : SW'(sum_fin);
  assign s_mag   = int'(s_abs);

  // Gain follows the state held before this update.
  always_comb begin
    ki = KI_SHIFT;
    kp = KP_SHIFT;
    if (state_q == ACQ) begin
      ki = KI_SHIFT + GEAR_EFF;
      kp = KP_SHIFT + GEAR_EFF;
    end
  end

  // Wide arithmetic so neither the integrator nor the P term can wrap before clamping.
  always_comb begin
    s_ext     = {{(AW-SW){sum_fin[SW-1]}}, sum_fin};
    integ_ext = {{(AW-32){integ_q[31]}}, integ_q};
    integ_n   = clamp(integ_ext + (s_ext <<< ki));
    v_n       = clamp(integ_n + (s_ext <<< kp));
  end

  always_comb begin
    state_n = state_q;
    quiet_n = quiet_q;
    if (close) begin
      case (state_q)
        ACQ: begin
          if (s_mag <= LOCK_THR) begin
            if (quiet_q + QW'(1) == QW'(LOCK_CNT)) begin
              state_n = LOCKED;
              quiet_n = '0;
            end else begin
              quiet_n = quiet_q + QW'(1);
            end
          end else begin
            quiet_n = '0;
          end
        end
        LOCKED: begin
          if (s_mag > UNLOCK_THR) begin
            state_n = ACQ;
            quiet_n = '0;
          end
        end
        default: begin
          state_n = ACQ;
          quiet_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACQ;
      quiet_q <= '0;
    end else begin
      state_q <= state_n;
      quiet_q <= quiet_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      sum_q      <= '0;
      integ_q    <= '0;
      v_ctrl_q   <= '0;
      win_done_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      win_done_q <= close;
      if (close) begin
        cnt_q    <= '0;
        sum_q    <= '0;
        integ_q  <= integ_n[31:0];
        v_ctrl_q <= v_n[31:0];
        sat_q    <= (integ_n == VMAX) || (integ_n == -VMAX);
      end else if (accept) begin
        cnt_q <= cnt_q + CW'(1);
        sum_q <= sum_fin;
      end
    end
  end

  assign lf.v_ctrl     = v_ctrl_q;
  assign lf.win_done   = win_done_q;
  assign lf.sat        = sat_q;
  assign lf.locked     = (state_q == LOCKED);
  assign lf.lock_state = state_q;
endmodule

// File: tb/tb_cdr_loop_filter.sv
// Directed bench for cdr_loop_filter: nominal-bound instance (a) and a V_MAX=100000 instance (b)
// share clock, reset and stimulus.
module tb_cdr_loop_filter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cdr_lf_if lf_a ();
  cdr_lf_if lf_b ();

  cdr_loop_filter dut_a (.clk(clk), .rst(rst), .lf(lf_a.slave));
  cdr_loop_filter #(.V_MAX(100000)) dut_b (.clk(clk), .rst(rst), .lf(lf_b.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic smp(input logic v, input logic u, input logic d, input logic f);
    lf_a.pd_valid = v; lf_a.pd_up = u; lf_a.pd_dn = d; lf_a.freeze = f;
    lf_b.pd_valid = v; lf_b.pd_up = u; lf_b.pd_dn = d; lf_b.freeze = f;
    @(posedge clk);
    #1;
  endtask

  task automatic win(input int n_up, input int n_dn);
    for (int i = 0; i < n_up; i++) smp(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n_dn; i++) smp(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    smp(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    smp(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    smp(1'b0, 1'b0, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    smp(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (lf_a.v_ctrl !== 32'sd0 || lf_a.win_done !== 1'b0 || lf_a.locked !== 1'b0 || lf_a.sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: v_ctrl=%0d win_done=%b locked=%b sat=%b, required 0/0/0/0",
               lf_a.v_ctrl, lf_a.win_done, lf_a.locked, lf_a.sat);
    end
    // reset in the middle of a window with votes pending
    for (int i = 0; i < 5; i++) smp(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checks++;
    if (lf_a.v_ctrl !== 32'sd0 || lf_a.win_done !== 1'b0 || lf_a.locked !== 1'b0 || lf_a.sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_window: v_ctrl=%0d win_done=%b locked=%b sat=%b, required 0/0/0/0",
               lf_a.v_ctrl, lf_a.win_done, lf_a.locked, lf_a.sat);
    end
    rst = 1'b0;
    win(15, 0);
    checks++;
    if (lf_a.win_done !== 1'b0 || lf_a.v_ctrl !== 32'sd0) begin
      failures++;
      $display("FAIL reset_partial_discard: win_done=%b v_ctrl=%0d after 15 fresh samples, required 0/0",
               lf_a.win_done, lf_a.v_ctrl);
    end
`ifndef CDR_LF_GEAR_SHIFT_EN
    win(1, 0);
    checks++;
    if (lf_a.win_done !== 1'b1 || lf_a.v_ctrl !== 32'sd1052672) begin
      failures++;
      $display("FAIL reset_full_window: win_done=%b v_ctrl=%0d, required 1/1052672", lf_a.win_done, lf_a.v_ctrl);
    end
`endif
  endtask

  task automatic test_window();
    do_reset();
    win(16, 0);
    checks++;
    if (lf_a.win_done !== 1'b1 || lf_a.v_ctrl !== 32'sd1052672) begin
      failures++;
      $display("FAIL window_up16: win_done=%b v_ctrl=%0d, required 1/1052672", lf_a.win_done, lf_a.v_ctrl);
    end
    checks++;
    if (lf_b.v_ctrl !== 32'sd100000 || lf_b.sat !== 1'b0) begin
      failures++;
      $display("FAIL window_vclamp_b: v_ctrl=%0d sat=%b, required 100000/0", lf_b.v_ctrl, lf_b.sat);
    end
    smp(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (lf_a.win_done !== 1'b0 || lf_a.v_ctrl !== 32'sd1052672) begin
      failures++;
      $display("FAIL window_strobe_one_cycle: win_done=%b v_ctrl=%0d, required 0/1052672", lf_a.win_done, lf_a.v_ctrl);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int w = 0; w < 3; w++) win(8, 8);
    checks++;
    if (lf_a.locked !== 1'b0 || lf_a.v_ctrl !== 32'sd0 || lf_a.lock_state !== 1'b0) begin
      failures++;
      $display("FAIL lock_after3: locked=%b v_ctrl=%0d, required 0/0", lf_a.locked, lf_a.v_ctrl);
    end
    win(9, 7);  // S=+2, on the quiet threshold
    checks++;
    if (lf_a.win_done !== 1'b1 || lf_a.locked !== 1'b1 || lf_a.v_ctrl !== 32'sd131584) begin
      failures++;
      $display("FAIL lock_after4: win_done=%b locked=%b v_ctrl=%0d, required 1/1/131584",
               lf_a.win_done, lf_a.locked, lf_a.v_ctrl);
    end
    win(12, 4);  // S=+8, on the unlock threshold
    checks++;
    if (lf_a.locked !== 1'b1 || lf_a.v_ctrl !== 32'sd526848) begin
      failures++;
      $display("FAIL lock_hold_s8: locked=%b v_ctrl=%0d, required 1/526848", lf_a.locked, lf_a.v_ctrl);
    end
    win(16, 0);
    checks++;
    if (lf_a.win_done !== 1'b1 || lf_a.locked !== 1'b0 || lf_a.v_ctrl !== 32'sd1055232) begin
      failures++;
      $display("FAIL lock_drop_s16: win_done=%b locked=%b v_ctrl=%0d, required 1/0/1055232",
               lf_a.win_done, lf_a.locked, lf_a.v_ctrl);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int w = 1; w <= 25; w++) begin
      win(16, 0);
      if (w == 24) begin
        checks++;
        if (lf_b.sat !== 1'b0) begin
          failures++;
          $display("FAIL sat_before_clamp: sat=%b after 24 windows, required 0", lf_b.sat);
        end
      end
    end
    checks++;
    if (lf_b.sat !== 1'b1 || lf_b.v_ctrl !== 32'sd100000 || lf_b.win_done !== 1'b1) begin
      failures++;
      $display("FAIL sat_clamp: sat=%b v_ctrl=%0d win_done=%b, required 1/100000/1",
               lf_b.sat, lf_b.v_ctrl, lf_b.win_done);
    end
    checks++;
    if (lf_a.sat !== 1'b0 || lf_a.v_ctrl !== 32'sd1150976) begin
      failures++;
      $display("FAIL sat_wide_bound_a: sat=%b v_ctrl=%0d, required 0/1150976", lf_a.sat, lf_a.v_ctrl);
    end
    win(0, 16);
    checks++;
    if (lf_b.sat !== 1'b0 || lf_b.v_ctrl !== -32'sd100000) begin
      failures++;
      $display("FAIL sat_release: sat=%b v_ctrl=%0d, required 0/-100000", lf_b.sat, lf_b.v_ctrl);
    end
    checks++;
    if (lf_a.v_ctrl !== -32'sd950272) begin
      failures++;
      $display("FAIL sat_dn_window_a: v_ctrl=%0d, required -950272", lf_a.v_ctrl);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 0; i < 5; i++) smp(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) smp(1'(i % 2), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) smp(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) smp(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (lf_a.win_done !== 1'b0 || lf_a.v_ctrl !== 32'sd0) begin
      failures++;
      $display("FAIL freeze_ignored: win_done=%b v_ctrl=%0d after 15 accepted, required 0/0", lf_a.win_done, lf_a.v_ctrl);
    end
    smp(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (lf_a.win_done !== 1'b0) begin
      failures++;
      $display("FAIL freeze_closing_cycle: win_done=%b, required 0", lf_a.win_done);
    end
    smp(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (lf_a.win_done !== 1'b1 || lf_a.v_ctrl !== 32'sd855296) begin
      failures++;
      $display("FAIL freeze_update: win_done=%b v_ctrl=%0d, required 1/855296", lf_a.win_done, lf_a.v_ctrl);
    end
  endtask

  task automatic test_gear();
    do_reset();
    win(16, 0);
    checks++;
    if (lf_a.win_done !== 1'b1 || lf_a.v_ctrl !== 32'sd16842752) begin
      failures++;
      $display("FAIL gear_acq: win_done=%b v_ctrl=%0d, required 1/16842752", lf_a.win_done, lf_a.v_ctrl);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    test_reset();
`ifdef CDR_LF_GEAR_SHIFT_EN
    test_gear();
`else
    test_window();
    test_lock();
    test_saturation();
    test_freeze();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
